// File: rtl/run_monitor_pkg.sv
// Shared types and helpers for the BARVINN run monitor.
//   run_status_e : result code reported on status
//   run_state_e  : run-control FSM states
//   cnt_width()  : bits needed to hold a counter that reaches max_val
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_NONE    = 2'd0,
    ST_PASS    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_STALL   = 2'd3
  } run_status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } run_state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/run_monitor_chan.sv
// Per-channel activity tracker: idle counter, sticky done and sticky stall.
//   clk, rst    : clock, synchronous active-high reset
//   en          : channel enabled for the current run (latched by the top)
//   run         : monitoring active this cycle
//   clear       : start of a new run, wipes counter and sticky bits
//   heartbeat   : activity strobe
//   done        : completion strobe
//   done_seen   : completion observed (forced high when disabled)
//   stalled     : sticky stall flag
module run_monitor_chan
  import run_monitor_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic run,
  input  logic clear,
  input  logic heartbeat,
  input  logic done,
  output logic done_seen,
  output logic stalled
);

  localparam int unsigned IDLE_W = cnt_width(STALL_CYCLES);
  localparam logic [IDLE_W-1:0] STALL_LIM = IDLE_W'(STALL_CYCLES);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              done_seen_q, done_seen_d;
  logic              stalled_q, stalled_d;

  // Idle counting uses the registered done bit, so a done arriving on the
  // stall cycle does not rescue the channel.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    done_seen_d = done_seen_q;
    stalled_d   = stalled_q;
    if (clear) begin
      idle_cnt_d  = '0;
      done_seen_d = 1'b0;
      stalled_d   = 1'b0;
    end else if (run && en) begin
      done_seen_d = done_seen_q | done;
      if (heartbeat || done_seen_q) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q != STALL_LIM) begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
      if (idle_cnt_d == STALL_LIM) begin
        stalled_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q  <= '0;
      done_seen_q <= 1'b0;
      stalled_q   <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      done_seen_q <= done_seen_d;
      stalled_q   <= stalled_d;
    end
  end

  // A disabled channel never holds up completion.
  assign done_seen = done_seen_q | ~en;
  assign stalled   = stalled_q;

endmodule

// File: rtl/barvinn_run_monitor.sv
// Run-control and watchdog for BARVINN harnesses: global cycle budget,
// per-channel stall detection, drain window and a single finish pulse.
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a run (honoured in IDLE/DONE/FAIL only)
//   ch_en       : channel enable mask, latched on an accepted start
//   heartbeat   : per-channel activity strobes
//   ch_done     : per-channel completion strobes (sticky)
//   busy        : high in RUN and DRAIN
//   finish      : one-cycle pulse on entry to DONE or FAIL
//   status      : run_status_e result code
//   stall_mask  : sticky per-channel stall flags
//   cycle_cnt   : RUN cycles elapsed in the current run
module barvinn_run_monitor
  import run_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned GLOBAL_TIMEOUT = 10000,
  parameter int unsigned STALL_CYCLES   = 1024,
  parameter int unsigned DRAIN_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] heartbeat,
  input  logic [NUM_CH-1:0] ch_done,
  output logic              busy,
  output logic              finish,
  output logic [1:0]        status,
  output logic [NUM_CH-1:0] stall_mask,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(GLOBAL_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST   = DRAIN_W'(DRAIN_CYCLES - 1);

  run_state_e        state_q, state_d;
  run_status_e       status_q, status_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  logic              chan_run_c;
  logic              chan_clear_c;
  logic [NUM_CH-1:0] done_seen_vec;
  logic [NUM_CH-1:0] stalled_vec;

  // Channel trackers.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    run_monitor_chan #(
      .STALL_CYCLES(STALL_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en        (en_q[i]),
      .run       (chan_run_c),
      .clear     (chan_clear_c),
      .heartbeat (heartbeat[i]),
      .done      (ch_done[i]),
      .done_seen (done_seen_vec[i]),
      .stalled   (stalled_vec[i])
    );
  end

  // Next-state and output logic. Exit checks look only at registered values;
  // on the exit cycle monitoring and counting stop so results stay frozen.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    en_d         = en_q;
    cycle_cnt_d  = cycle_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    chan_run_c   = 1'b0;
    chan_clear_c = 1'b0;

    case (state_q)
      IDLE, DONE, FAIL: begin
        if (start) begin
          chan_clear_c = 1'b1;
          en_d         = ch_en;
          cycle_cnt_d  = '0;
          drain_cnt_d  = '0;
          if (ch_en == '0) begin
            state_d  = DRAIN;
            status_d = ST_PASS;
          end else begin
            state_d  = RUN;
            status_d = ST_NONE;
          end
        end
      end
      RUN: begin
        if (cycle_cnt_q == TIMEOUT_LAST) begin
          state_d  = FAIL;
          status_d = ST_TIMEOUT;
        end else if (|stalled_vec) begin
          state_d  = FAIL;
          status_d = ST_STALL;
        end else if (&done_seen_vec) begin
          state_d  = DRAIN;
          status_d = ST_PASS;
        end else begin
          chan_run_c  = 1'b1;
          cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d == RUN) || (state_d == DRAIN);
    finish_d = ((state_q == RUN) || (state_q == DRAIN)) &&
               ((state_d == DONE) || (state_d == FAIL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      status_q    <= ST_NONE;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      en_q        <= '0;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
      en_q        <= en_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign finish     = finish_q;
  assign status     = status_q;
  assign stall_mask = stalled_vec;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_barvinn_run_monitor.sv
// Scoreboard bench for barvinn_run_monitor: each run's outcome is predicted
// from the heartbeat/done tables and queued; a monitor checks every finish.
module tb_barvinn_run_monitor;

  localparam int NCH = 4;
  localparam int GT  = 200;
  localparam int SC  = 20;
  localparam int DC  = 4;
  localparam int INF = 1000000;

  localparam int S_NONE = 0, S_PASS = 1, S_TIMEOUT = 2, S_STALL = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] heartbeat;
  logic [NCH-1:0] ch_done;
  logic           busy;
  logic           finish;
  logic [1:0]     status;
  logic [NCH-1:0] stall_mask;
  logic [31:0]    cycle_cnt;

  barvinn_run_monitor #(
    .NUM_CH(NCH), .CNT_W(32), .GLOBAL_TIMEOUT(GT),
    .STALL_CYCLES(SC), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_en(ch_en),
    .heartbeat(heartbeat), .ch_done(ch_done), .busy(busy), .finish(finish),
    .status(status), .stall_mask(stall_mask), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ft;   // cycle (cyc value) at which finish must be seen
    int st;
    int sm;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [NCH-1:0] hb_a [GT];
  logic [NCH-1:0] dn_a [GT];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference: per channel, find when its done becomes visible and when a
  // run of SC consecutive quiet cycles completes; the earliest event wins.
  function automatic exp_t model(input logic [NCH-1:0] m, input int k);
    exp_t r;
    int sv [NCH];
    int fd, quiet, e, smin, pvis;
    if (m == '0) begin
      r.ft = k + DC; r.st = S_PASS; r.sm = 0; r.cnt = 0;
      return r;
    end
    smin = INF;
    pvis = 0;
    for (int i = 0; i < NCH; i++) begin
      sv[i] = INF;
      if (m[i]) begin
        fd = INF;
        for (int c = 0; c < GT; c++) if (dn_a[c][i] && fd == INF) fd = c;
        if (fd == INF) pvis = INF;
        else if (fd + 1 > pvis) pvis = fd + 1;
        quiet = 0;
        for (int c = 0; c < GT; c++) begin
          if (hb_a[c][i] || c > fd) quiet = 0;
          else quiet++;
          if (quiet == SC && sv[i] == INF) sv[i] = c + 1;
        end
        if (sv[i] < smin) smin = sv[i];
      end
    end
    e = GT - 1;
    if (smin < e) e = smin;
    if (pvis < e) e = pvis;
    r.cnt = e;
    r.sm  = 0;
    for (int i = 0; i < NCH; i++) if (sv[i] <= e) r.sm |= (1 << i);
    if (e == GT - 1) begin
      r.st = S_TIMEOUT; r.ft = k + e + 1;
    end else if (smin == e) begin
      r.st = S_STALL; r.ft = k + e + 1;
    end else begin
      r.st = S_PASS; r.ft = k + e + 1 + DC;
    end
    return r;
  endfunction

  // Monitor: every finish pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (finish === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_finish", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("status", 32'(status), 32'(e.st));
        chk("stall_mask", 32'(stall_mask), 32'(e.sm));
        chk("cycle_cnt", cycle_cnt, 32'(e.cnt));
        chk("finish_cycle", 32'(cyc), 32'(e.ft));
      end
    end else if (finish !== 1'b0) begin
      chk("finish_known", 32'(finish), 32'd0);
    end
  end

  task automatic fill(input int sc, output logic [NCH-1:0] m);
    int dt, gs, gl, dens;
    for (int c = 0; c < GT; c++) begin
      hb_a[c] = '0;
      dn_a[c] = '0;
    end
    case (sc)
      0: begin  // all channels pass
        m = 4'b1111;
        for (int c = 0; c < GT; c++) for (int i = 0; i < NCH; i++) hb_a[c][i] = (c % 5 == 0);
        for (int i = 0; i < NCH; i++) dn_a[30 + 10 * i][i] = 1'b1;
      end
      1: begin  // ch1 goes silent
        m = 4'b0011;
        for (int c = 0; c < GT; c++) begin
          hb_a[c][0] = (c % 5 == 0);
          hb_a[c][1] = (c % 5 == 0) && (c <= 10);
        end
      end
      2, 7: begin  // busy forever, never done
        m = 4'b1111;
        for (int c = 0; c < GT; c++) hb_a[c] = 4'b1111;
      end
      3: begin  // stall flag lands on the timeout cycle
        m = 4'b0001;
        for (int c = 0; c < GT; c++) hb_a[c][0] = ((c % 3 == 0) || (c == 178)) && (c <= 178);
      end
      4: begin  // final done arrives on the stall cycle
        m = 4'b0011;
        for (int c = 0; c < GT; c++) begin
          hb_a[c][0] = (c % 2 == 0);
          hb_a[c][1] = (c <= 10);
        end
        dn_a[5][0]  = 1'b1;
        dn_a[30][1] = 1'b1;
      end
      5: m = 4'b0000;
      6: begin  // ch2 disabled and silent
        m = 4'b1011;
        for (int c = 0; c < GT; c++) begin
          hb_a[c][0] = (c % 4 == 0);
          hb_a[c][1] = (c % 4 == 0);
          hb_a[c][3] = (c % 4 == 0);
        end
        dn_a[20][0] = 1'b1;
        dn_a[25][1] = 1'b1;
        dn_a[30][3] = 1'b1;
      end
      default: begin
        m = 4'($urandom_range(0, 15));
        for (int i = 0; i < NCH; i++) begin
          dt   = ($urandom_range(0, 3) == 0) ? INF : int'($urandom_range(5, 220));
          gs   = int'($urandom_range(0, 199));
          gl   = int'($urandom_range(0, 40));
          dens = int'($urandom_range(30, 90));
          for (int c = 0; c < GT; c++) begin
            hb_a[c][i] = (int'($urandom_range(0, 99)) < dens) && !(c >= gs && c < gs + gl);
            dn_a[c][i] = (c == dt) || ($urandom_range(0, 299) == 0);
          end
        end
      end
    endcase
  endtask

  task automatic do_run(input int sc, input int abort_at);
    logic [NCH-1:0] m;
    exp_t e;
    int k, c;
    fill(sc, m);
    start = 1'b1; ch_en = m; heartbeat = '0; ch_done = '0;
    @(negedge clk);
    k = cyc;
    start = 1'b0;
    ch_en = 4'($urandom);
    e = model(m, k);
    exp_q.push_back(e);
    #1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_cycle_cnt", cycle_cnt, 32'd0);
    chk("start_stall_mask", 32'(stall_mask), 32'd0);
    chk("start_status", 32'(status), (m == '0) ? 32'(S_PASS) : 32'(S_NONE));
    while (cyc < e.ft) begin
      c = cyc - k;
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_stall_mask", 32'(stall_mask), 32'd0);
        chk("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b0; start = 1'b0; heartbeat = '0; ch_done = '0;
        void'(exp_q.pop_back());
        return;
      end
      heartbeat = (c < GT) ? hb_a[c] : '0;
      ch_done   = (c < GT) ? dn_a[c] : '0;
      start     = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    #1;
    chk("finish_seen", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    start = 1'b0; heartbeat = '0; ch_done = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ch_en = '0; heartbeat = '0; ch_done = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_finish", 32'(finish), 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_stall_mask", 32'(stall_mask), 32'd0);
    chk("reset_cycle_cnt", cycle_cnt, 32'd0);
    rst = 1'b0;
    idle(2);

    do_run(0, -1); idle(3);
    do_run(1, -1);
    do_run(6, -1);          // restart from FAIL on the finish cycle
    do_run(2, -1); idle(2);
    do_run(3, -1);
    do_run(4, -1);
    do_run(5, -1); idle(2);
    do_run(7, 50); idle(3); // reset mid-run
    do_run(0, -1);
    for (int r = 0; r < 24; r++) begin
      do_run(100, -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
    end
    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
